// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D part. It returns the channel
// addressed by the previous complete 16-bit command, MSB first.
module a2d_spi_resp #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] ch_vals,
  output logic                     cmd_vld,
  output logic [2:0]               cmd_chnnl,
  output logic                     frm_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state, w_next;
  logic        r_ss_1, r_ss_2, r_ss_3;
  logic        r_sclk_1, r_sclk_2, r_sclk_3;
  logic        r_mosi_1, r_mosi_2;
  logic [15:0] r_tx_shft;
  logic [13:0] r_rx_shft;
  logic [4:0]  r_bit_cnt;
  logic        r_seen_rise, r_start_pend;
  logic [2:0]  r_addr, r_cmd_chnnl;
  logic        r_cmd_vld, r_frm_err;

  logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic        w_start, w_do_rx, w_do_tx, w_cmd_ok, w_cmd_bad, w_pend_set;
  logic [15:0] w_tx_load;

  // NOTE: non-blocking assignments in clocked blocks so each flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_1   <= 1'b1;
      r_ss_2   <= 1'b1;
      r_ss_3   <= 1'b1;
      r_sclk_1 <= 1'b1;
      r_sclk_2 <= 1'b1;
      r_sclk_3 <= 1'b1;
      r_mosi_1 <= 1'b0;
      r_mosi_2 <= 1'b0;
    end else begin
      r_ss_1   <= SS_n;
      r_ss_2   <= r_ss_1;
      r_ss_3   <= r_ss_2;
      r_sclk_1 <= SCLK;
      r_sclk_2 <= r_sclk_1;
      r_sclk_3 <= r_sclk_2;
      r_mosi_1 <= MOSI;
      r_mosi_2 <= r_mosi_1;
    end
  end

  assign w_ss_fall   =  r_ss_3   & ~r_ss_2;
  assign w_ss_rise   = ~r_ss_3   &  r_ss_2;
  assign w_sclk_fall =  r_sclk_3 & ~r_sclk_2;
  assign w_sclk_rise = ~r_sclk_3 &  r_sclk_2;

  always_comb begin
    w_tx_load = '0;
    if (int'(r_addr) < NUM_CH)
      w_tx_load[DATA_W-1:0] = ch_vals[int'(r_addr)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_do_rx    = 1'b0;
    w_do_tx    = 1'b0;
    w_cmd_ok   = 1'b0;
    w_cmd_bad  = 1'b0;
    w_pend_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall || r_start_pend) begin
          w_start = 1'b1;
          w_next  = SHIFT;
        end
      end
      SHIFT: begin
        w_do_rx = w_sclk_rise;
        // The leading fall from idle-high SCLK must not consume bit 15.
        w_do_tx = w_sclk_fall && r_seen_rise;
        if (w_ss_rise) w_next = DONE;
      end
      DONE: begin
        w_next     = IDLE;
        w_pend_set = w_ss_fall;
        if (r_bit_cnt == 5'd16) w_cmd_ok  = 1'b1;
        else                    w_cmd_bad = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the shift registers are reset as well so MISO and the next address are clean after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shft    <= '0;
      r_rx_shft    <= '0;
      r_bit_cnt    <= '0;
      r_seen_rise  <= 1'b0;
      r_start_pend <= 1'b0;
      r_addr       <= '0;
      r_cmd_chnnl  <= '0;
      r_cmd_vld    <= 1'b0;
      r_frm_err    <= 1'b0;
    end else begin
      r_cmd_vld    <= w_cmd_ok;
      r_frm_err    <= w_cmd_bad;
      r_start_pend <= w_pend_set;
      if (w_start) begin
        r_tx_shft   <= w_tx_load;
        r_rx_shft   <= '0;
        r_bit_cnt   <= '0;
        r_seen_rise <= 1'b0;
      end else begin
        // Only 14 bits are kept: the top two command bits are don't-care.
        if (w_do_rx) begin
          r_rx_shft   <= {r_rx_shft[12:0], r_mosi_2};
          r_seen_rise <= 1'b1;
          if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        if (w_do_tx) r_tx_shft <= {r_tx_shft[14:0], 1'b0};
      end
      if (w_cmd_ok) begin
        r_addr      <= r_rx_shft[13:11];
        r_cmd_chnnl <= r_rx_shft[13:11];
      end
    end
  end

  assign MISO      = (r_state == SHIFT) && (r_bit_cnt < 5'd16) && r_tx_shft[15];
  assign cmd_vld   = r_cmd_vld;
  assign frm_err   = r_frm_err;
  assign cmd_chnnl = r_cmd_chnnl;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: the bench acts as SPI master, a queue-based model
// predicts returned words and end-of-frame pulses, and monitors compare them.
module tb_a2d_spi_resp;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int PH     = 6;

  logic clk = 1'b0, rst = 1'b1, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_vals = '0;
  logic MISO, cmd_vld, frm_err;
  logic [2:0] cmd_chnnl;

  typedef struct packed {logic vld; logic err; logic [2:0] ch;} evt_t;

  evt_t        exp_evt_q[$];
  logic [15:0] exp_word_q[$];
  int          n_checks = 0, n_fail = 0;

  logic [DATA_W-1:0] m_vals[NUM_CH];
  int                m_addr  = 0;
  logic [2:0]        m_chnnl = '0;

  int          mon_cnt   = 0;
  logic [15:0] mon_word  = '0;
  bit          mon_abort = 1'b0;

  a2d_spi_resp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_vals(ch_vals), .cmd_vld(cmd_vld), .cmd_chnnl(cmd_chnnl), .frm_err(frm_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_missing(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no expectation queued (t=%0t)", name, $time);
  endtask

  task automatic apply_vals();
    for (int n = 0; n < NUM_CH; n++) ch_vals[n*DATA_W +: DATA_W] = m_vals[n];
  endtask

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch, input bit noisy);
    logic [15:0] c;
    c = {2'b00, ch, 11'h000};
    if (noisy) begin
      c[15:14] = 2'($urandom);
      c[10:0]  = 11'($urandom);
    end
    return c;
  endfunction

  // Serial word monitor: master samples MISO on every SCLK rise.
  always @(posedge SCLK) begin
    if (!SS_n && !rst) begin
      if (mon_cnt < 16) mon_word[15-mon_cnt] = MISO;
      else              check("miso_after_bit16", {31'd0, MISO}, 32'd0);
      mon_cnt++;
    end
  end

  always @(negedge SS_n) begin
    mon_cnt   = 0;
    mon_abort = 1'b0;
  end

  always @(posedge rst) mon_abort = 1'b1;

  always @(posedge SS_n) begin
    if (!mon_abort && mon_cnt >= 16) begin
      if (exp_word_q.size() == 0) report_missing("miso_word");
      else check("miso_word", {16'd0, mon_word}, {16'd0, exp_word_q.pop_front()});
    end
  end

  // End-of-frame pulse monitor.
  always @(negedge clk) begin
    if (!rst && (cmd_vld || frm_err)) begin
      if (exp_evt_q.size() == 0) report_missing("frame_event");
      else check("frame_event", {27'd0, cmd_vld, frm_err, cmd_chnnl}, {27'd0, exp_evt_q.pop_front()});
    end
  end

  task automatic run_frame(input logic [15:0] cmd, input int nbits, input int chg_at, input int rst_at);
    logic [15:0] exp_w;
    exp_w = '0;
    if (m_addr < NUM_CH) exp_w[DATA_W-1:0] = m_vals[m_addr];
    if (nbits >= 16 && rst_at < 0) exp_word_q.push_back(exp_w);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'($urandom);
      if (i == chg_at) begin
        for (int n = 0; n < NUM_CH; n++) m_vals[n] = DATA_W'($urandom);
        apply_vals();
      end
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_miso",      {31'd0, MISO},      32'd0);
        check("rst_cmd_vld",   {31'd0, cmd_vld},   32'd0);
        check("rst_cmd_chnnl", {29'd0, cmd_chnnl}, 32'd0);
        SS_n = 1'b1;
        SCLK = 1'b1;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        m_addr  = 0;
        m_chnnl = '0;
        repeat (PH) @(negedge clk);
        return;
      end
      repeat (PH) @(negedge clk);
      SCLK = 1'b1;
      repeat (PH) @(negedge clk);
    end
    SS_n = 1'b1;
    if (nbits == 16) begin
      m_addr  = int'(cmd[13:11]);
      m_chnnl = cmd[13:11];
      exp_evt_q.push_back('{vld: 1'b1, err: 1'b0, ch: m_chnnl});
    end else begin
      exp_evt_q.push_back('{vld: 1'b0, err: 1'b1, ch: m_chnnl});
    end
    repeat (PH) @(negedge clk);
  endtask

  initial begin
    #(20ns * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, ch, chg;
    for (int n = 0; n < NUM_CH; n++) m_vals[n] = '0;
    apply_vals();
    repeat (3) @(negedge clk);
    check("reset_miso",      {31'd0, MISO},      32'd0);
    check("reset_cmd_vld",   {31'd0, cmd_vld},   32'd0);
    check("reset_frm_err",   {31'd0, frm_err},   32'd0);
    check("reset_cmd_chnnl", {29'd0, cmd_chnnl}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // First frame after reset returns channel 0.
    m_vals[0] = 12'hABC;
    apply_vals();
    run_frame(mk_cmd(3'd3, 1'b0), 16, -1, -1);

    // Pipelined addressing.
    m_vals[3] = 12'h123;
    m_vals[5] = 12'h5A5;
    m_vals[1] = 12'hF0F;
    apply_vals();
    run_frame(mk_cmd(3'd5, 1'b0), 16, -1, -1);
    run_frame(mk_cmd(3'd1, 1'b0), 16, -1, -1);

    // Short frame keeps the old address; long frame also errors.
    run_frame(mk_cmd(3'd6, 1'b0), 9, -1, -1);
    run_frame(mk_cmd(3'd7, 1'b0), 17, -1, -1);
    run_frame(mk_cmd(3'd2, 1'b0), 16, -1, -1);

    // Value frozen at SS_n fall despite a mid-frame change.
    run_frame(mk_cmd(3'd4, 1'b0), 16, 5, -1);
    run_frame(mk_cmd(3'd0, 1'b0), 16, -1, -1);

    // Reset in the middle of bit 7, then a clean frame from channel 0.
    run_frame(mk_cmd(3'd6, 1'b0), 16, -1, 7);
    run_frame(mk_cmd(3'd4, 1'b0), 16, -1, -1);

    for (int k = 0; k < 80; k++) begin
      ch  = int'($urandom_range(0, 7));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      chg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      if ($urandom_range(0, 3) == 0) begin
        for (int n = 0; n < NUM_CH; n++) m_vals[n] = DATA_W'($urandom);
        apply_vals();
      end
      run_frame(mk_cmd(3'(ch), 1'b1), nb, chg, -1);
    end

    repeat (20) @(negedge clk);
    check("evt_queue_drained",  exp_evt_q.size(),  32'd0);
    check("word_queue_drained", exp_word_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
